// File: rtl/sdr_msoc_ocimem_arbiter.sv
// OCI debug RAM arbiter: JTAG vs CPU Avalon-MM, one access at a time.
// Define OCIMEM_JTAG_PRIORITY_EN for fixed JTAG priority instead of round-robin.
module sdr_msoc_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_req,
  input  logic              jtag_write,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [31:0]       jtag_wdata,
  output logic              jtag_ack,
  output logic [31:0]       jtag_rdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_byteenable,
  output logic              cpu_waitrequest,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  input  logic [31:0]       ram_rdata,
  output logic              grant_jtag
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDATA  = 2'd2;

  logic [1:0]        state;
  logic              own_jtag;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic              last_jtag;
  logic              jack_rd_q;
  logic              cpu_rdv_q;
  logic [31:0]       jtag_rdata_q;
  logic [31:0]       cpu_rdata_q;

  logic jtag_pend;
  logic cpu_pend;
  logic pick_jtag;
  logic acc;

  // JTAG still holds req in the cycle its read ack pulses; do not re-grant it
  assign jtag_pend = jtag_req && !jack_rd_q;
  assign cpu_pend  = cpu_read || cpu_write;

`ifdef OCIMEM_JTAG_PRIORITY_EN
  assign pick_jtag = jtag_pend;
`else
  assign pick_jtag = jtag_pend && (!cpu_pend || !last_jtag);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      own_jtag     <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      last_jtag    <= 1'b0;
      jack_rd_q    <= 1'b0;
      cpu_rdv_q    <= 1'b0;
      jtag_rdata_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      jack_rd_q <= 1'b0;
      cpu_rdv_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (jtag_pend || cpu_pend) begin
            state     <= ACCESS;
            own_jtag  <= pick_jtag;
            last_jtag <= pick_jtag;
            if (pick_jtag) begin
              we_q    <= jtag_write;
              addr_q  <= jtag_addr;
              wdata_q <= jtag_wdata;
              be_q    <= 4'hF;
            end else begin
              we_q    <= cpu_write;
              addr_q  <= cpu_addr;
              wdata_q <= cpu_wdata;
              be_q    <= cpu_byteenable;
            end
          end
        end
        ACCESS: begin
          state <= we_q ? IDLE : RDATA;
        end
        RDATA: begin
          state <= IDLE;
          if (own_jtag) begin
            jtag_rdata_q <= ram_rdata;
            jack_rd_q    <= 1'b1;
          end else begin
            cpu_rdata_q <= ram_rdata;
            cpu_rdv_q   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign acc = (state == ACCESS);

  assign ram_en    = acc;
  assign ram_we    = acc && we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_be    = be_q;

  assign jtag_ack   = (acc && own_jtag && we_q) || jack_rd_q;
  assign jtag_rdata = jtag_rdata_q;

  assign cpu_waitrequest   = cpu_pend && !(acc && !own_jtag);
  assign cpu_readdata      = cpu_rdata_q;
  assign cpu_readdatavalid = cpu_rdv_q;

  assign grant_jtag = last_jtag;

endmodule
